// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and command output handshakes of the UART frame decoder.
// The slave view belongs to the decoder; the master view belongs to its environment.
interface uart_frame_decoder_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (
    output rx_valid, rx_data, cmd_ready,
    input  rx_ready, cmd_valid, cmd_op, cmd_addr, cmd_data
  );

  modport slave (
    input  rx_valid, rx_data, cmd_ready,
    output rx_ready, cmd_valid, cmd_op, cmd_addr, cmd_data
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles [SYNC][OP][ADDR][DATA][CSUM] frames from a UART byte stream and issues
// checksum-validated commands, counting checksum failures and inter-byte timeouts.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 500_000,
  parameter int         TO_WIDTH       = 20,
  parameter int         ERR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_frame_decoder_if.slave  bus,
  output logic                 busy,
  input  logic                 clr_err,
  output logic [ERR_WIDTH-1:0] err_csum_cnt,
  output logic [ERR_WIDTH-1:0] err_to_cnt
);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_GET_OP,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM,
    ST_OUT
  } state_t;

  localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state_reg;
  logic [7:0]          acc_reg;
  logic [7:0]          op_reg;
  logic [7:0]          addr_reg;
  logic [7:0]          data_reg;
  logic                cmd_valid_reg;
  logic [TO_WIDTH-1:0] to_cnt_reg;

  logic accept;
  logic in_get;
  logic to_expire;
  logic csum_fail;

  assign bus.rx_ready  = (state_reg != ST_OUT);
  assign bus.cmd_valid = cmd_valid_reg;
  assign bus.cmd_op    = op_reg;
  assign bus.cmd_addr  = addr_reg;
  assign bus.cmd_data  = data_reg;
  assign busy          = (state_reg != ST_HUNT);

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign in_get    = (state_reg == ST_GET_OP)   || (state_reg == ST_GET_ADDR) ||
                     (state_reg == ST_GET_DATA) || (state_reg == ST_GET_CSUM);
  // An accepted byte in the expiry cycle beats the timeout.
  assign to_expire = TO_EN && in_get && !accept && (to_cnt_reg == TO_LAST);
  assign csum_fail = (state_reg == ST_GET_CSUM) && accept && (bus.rx_data != acc_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_HUNT;
      acc_reg       <= 8'h00;
      op_reg        <= 8'h00;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      cmd_valid_reg <= 1'b0;
      to_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_HUNT: begin
          if (accept && (bus.rx_data == SYNC_BYTE)) begin
            state_reg <= ST_GET_OP;
            acc_reg   <= 8'h00;
          end
        end
        ST_GET_OP: begin
          if (accept) begin
            op_reg    <= bus.rx_data;
            acc_reg   <= bus.rx_data;
            state_reg <= ST_GET_ADDR;
          end
        end
        ST_GET_ADDR: begin
          if (accept) begin
            addr_reg  <= bus.rx_data;
            acc_reg   <= acc_reg ^ bus.rx_data;
            state_reg <= ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (accept) begin
            data_reg  <= bus.rx_data;
            acc_reg   <= acc_reg ^ bus.rx_data;
            state_reg <= ST_GET_CSUM;
          end
        end
        ST_GET_CSUM: begin
          if (accept) begin
            if (bus.rx_data == acc_reg) begin
              state_reg     <= ST_OUT;
              cmd_valid_reg <= 1'b1;
            end else begin
              state_reg <= ST_HUNT;
            end
          end
        end
        ST_OUT: begin
          if (cmd_valid_reg && bus.cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            state_reg     <= ST_HUNT;
          end
        end
        default: begin
          state_reg     <= ST_HUNT;
          cmd_valid_reg <= 1'b0;
        end
      endcase

      if (to_expire) begin
        state_reg <= ST_HUNT;
      end

      // Idle counter only advances between bytes of a frame in progress.
      if (!TO_EN || !in_get || accept || to_expire) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  // Index 0 counts checksum failures, index 1 counts timeouts.
  logic [1:0]           err_inc;
  logic [ERR_WIDTH-1:0] err_cnt_reg [2];

  assign err_inc = {to_expire, csum_fail};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_cnt_reg[gi] <= '0;
        end else if (clr_err) begin
          err_cnt_reg[gi] <= '0;
        end else if (err_inc[gi] && (err_cnt_reg[gi] != '1)) begin
          err_cnt_reg[gi] <= err_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign err_csum_cnt = err_cnt_reg[0];
  assign err_to_cnt   = err_cnt_reg[1];

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomized and directed stimulus for uart_frame_decoder, checked every cycle against
// a frame-buffer reference model built on queues, plus hand-computed expectations.
module tb_uart_frame_decoder;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TO      = 16;
  localparam int         ERR_W   = 8;
  localparam int         ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_err;
  logic             busy;
  logic [ERR_W-1:0] err_csum_cnt;
  logic [ERR_W-1:0] err_to_cnt;

  uart_frame_decoder_if bus_if ();

  uart_frame_decoder #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (20),
    .ERR_WIDTH      (ERR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if.slave),
    .busy         (busy),
    .clr_err      (clr_err),
    .err_csum_cnt (err_csum_cnt),
    .err_to_cnt   (err_to_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Upstream FIFO entries: {clr_err, idle-cycle marker, byte}
  logic [9:0] fifo_q[$];
  int         gap_pct    = 0;
  int         ready_mode = 0;
  bit         pop_next   = 0;
  int         dut_fires  = 0;
  logic [7:0] last_op = 8'h00, last_addr = 8'h00, last_data = 8'h00;

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back({2'b00, b});
  endtask

  task automatic push_gaps(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(10'h100);
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input bit bad);
    logic [7:0] cs;
    cs = op ^ addr ^ data;
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    push_byte(SYNC); push_byte(op); push_byte(addr); push_byte(data); push_byte(cs);
  endtask

  // Driver: presents FIFO head each negedge, pops once the byte was taken.
  initial begin
    logic [9:0] e;
    bus_if.rx_valid  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.cmd_ready = 1'b0;
    clr_err          = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_next && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_next = 1'b0;
      case (ready_mode)
        0:       bus_if.cmd_ready = 1'b1;
        1:       bus_if.cmd_ready = 1'($urandom_range(0, 1));
        default: bus_if.cmd_ready = 1'b0;
      endcase
      clr_err         = 1'b0;
      bus_if.rx_valid = 1'b0;
      if (fifo_q.size() > 0 && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct)) begin
        e               = fifo_q[0];
        clr_err         = e[9];
        bus_if.rx_valid = !e[8];
        bus_if.rx_data  = e[7:0];
        pop_next        = e[8] || bus_if.rx_ready;
      end else begin
        bus_if.rx_data = 8'($urandom_range(0, 255));
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        dut_fires++;
        last_op   = bus_if.cmd_op;
        last_addr = bus_if.cmd_addr;
        last_data = bus_if.cmd_data;
        $display("cmd %0d: op=%02h addr=%02h data=%02h", dut_fires, last_op, last_addr, last_data);
      end
    end
  end

  // Reference model: a buffer of collected frame bytes and an idle-cycle count.
  logic [7:0] frame_q[$];
  int         idle       = 0;
  bit         m_pending  = 0;
  logic [7:0] m_op, m_addr, m_data;
  int         m_csum_err = 0;
  int         m_to_err   = 0;
  int         m_fires    = 0;

  task automatic model_step();
    bit acc;
    if (!rst_n) begin
      frame_q.delete();
      idle = 0; m_pending = 0; m_csum_err = 0; m_to_err = 0;
      return;
    end
    acc = bus_if.rx_valid && !m_pending;
    if (m_pending) begin
      if (bus_if.cmd_ready) begin
        m_pending = 0;
        m_fires++;
      end
    end else if (acc) begin
      if (frame_q.size() == 0) begin
        if (bus_if.rx_data == SYNC) frame_q.push_back(bus_if.rx_data);
      end else begin
        frame_q.push_back(bus_if.rx_data);
        if (frame_q.size() == 5) begin
          if ((frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4]) begin
            m_pending = 1;
            m_op = frame_q[1]; m_addr = frame_q[2]; m_data = frame_q[3];
          end else if (m_csum_err < ERR_MAX) begin
            m_csum_err++;
          end
          frame_q.delete();
        end
      end
      idle = 0;
    end else if (frame_q.size() > 0) begin
      if (idle == TO - 1) begin
        frame_q.delete();
        idle = 0;
        if (m_to_err < ERR_MAX) m_to_err++;
      end else begin
        idle++;
      end
    end
    if (clr_err) begin
      m_csum_err = 0;
      m_to_err   = 0;
    end
  endtask

  // Compare process: after each edge, advance the model and check every output.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("rx_ready", bus_if.rx_ready, !m_pending);
      check("cmd_valid", bus_if.cmd_valid, m_pending);
      check("busy", busy, (m_pending || frame_q.size() > 0));
      check("err_csum_cnt", err_csum_cnt, m_csum_err);
      check("err_to_cnt", err_to_cnt, m_to_err);
      if (m_pending) begin
        check("cmd_op", bus_if.cmd_op, m_op);
        check("cmd_addr", bus_if.cmd_addr, m_addr);
        check("cmd_data", bus_if.cmd_data, m_data);
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() > 0 || pop_next) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, (fifo_q.size() == 0), 1);
    settle(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    settle(3);
    check("rst_cmd_valid", bus_if.cmd_valid, 0);
    check("rst_cmd_op", bus_if.cmd_op, 0);
    check("rst_cmd_addr", bus_if.cmd_addr, 0);
    check("rst_cmd_data", bus_if.cmd_data, 0);
    check("rst_err_csum", err_csum_cnt, 0);
    check("rst_err_to", err_to_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_ready", bus_if.rx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic valid frame
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10); push_byte(8'h5A); push_byte(8'h4B);
    wait_drain("t1", 100);
    check("t1_fires", dut_fires, 1);
    check("t1_model_fires", m_fires, 1);
    check("t1_op", last_op, 8'h01);
    check("t1_addr", last_addr, 8'h10);
    check("t1_data", last_data, 8'h5A);
    check("t1_err_csum", err_csum_cnt, 0);
    check("t1_busy", busy, 0);

    // Bad checksum, then a good frame
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10); push_byte(8'h5A); push_byte(8'h4C);
    wait_drain("t2a", 100);
    check("t2_err_csum", err_csum_cnt, 1);
    check("t2_model_err_csum", m_csum_err, 1);
    check("t2_no_cmd", dut_fires, 1);
    push_frame(8'h03, 8'h30, 8'hC3, 0);
    wait_drain("t2b", 100);
    check("t2_fires", dut_fires, 2);
    check("t2_op", last_op, 8'h03);

    // Garbage ahead of SYNC
    push_byte(8'h00); push_byte(8'hFF);
    push_byte(8'hA5); push_byte(8'h02); push_byte(8'h20); push_byte(8'h33); push_byte(8'h11);
    wait_drain("t3", 100);
    check("t3_fires", dut_fires, 3);
    check("t3_op", last_op, 8'h02);
    check("t3_addr", last_addr, 8'h20);
    check("t3_data", last_data, 8'h33);

    // Timeout after 16 idle cycles, then a byte landing exactly on expiry
    push_byte(8'hA5); push_byte(8'h01); push_gaps(16);
    wait_drain("t4a", 100);
    check("t4_err_to", err_to_cnt, 1);
    check("t4_model_err_to", m_to_err, 1);
    check("t4_busy", busy, 0);
    push_byte(8'hA5); push_byte(8'h01); push_gaps(15);
    push_byte(8'h10); push_byte(8'h5A); push_byte(8'h4B);
    wait_drain("t4b", 100);
    check("t4_err_to_kept", err_to_cnt, 1);
    check("t4_fires", dut_fires, 4);
    check("t4_op", last_op, 8'h01);

    // Back-pressure with a second frame queued
    ready_mode = 2;
    push_frame(8'h0A, 8'h0B, 8'h0C, 0);
    push_frame(8'h21, 8'h22, 8'h23, 0);
    settle(30);
    check("t5_cmd_valid", bus_if.cmd_valid, 1);
    check("t5_rx_ready", bus_if.rx_ready, 0);
    check("t5_op_held", bus_if.cmd_op, 8'h0A);
    check("t5_fifo_held", fifo_q.size(), 5);
    ready_mode = 0;
    wait_drain("t5", 100);
    check("t5_fires", dut_fires, 6);
    check("t5_op2", last_op, 8'h21);
    check("t5_data2", last_data, 8'h23);

    // Saturation and clear-wins
    for (int i = 0; i < 300; i++) begin
      push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10); push_byte(8'h5A); push_byte(8'h00);
    end
    wait_drain("t6a", 4000);
    check("t6_sat", err_csum_cnt, 8'hFF);
    check("t6_model_sat", m_csum_err, 255);
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10); push_byte(8'h5A);
    fifo_q.push_back(10'h200);
    wait_drain("t6b", 100);
    check("t6_clr_wins", err_csum_cnt, 0);
    check("t6_clr_to", err_to_cnt, 0);
    push_frame(8'h55, 8'h66, 8'h77, 1);
    wait_drain("t6c", 100);
    check("t6_recount", err_csum_cnt, 1);
    fifo_q.push_back(10'h300);
    wait_drain("t6d", 100);
    check("t6_clr_pulse", err_csum_cnt, 0);

    // Randomized traffic
    gap_pct    = 15;
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      push_frame(8'($urandom), 8'($urandom), 8'($urandom), 0);
      else if (r < 70) push_frame(8'($urandom), 8'($urandom), 8'($urandom), 1);
      else if (r < 80) push_byte(8'($urandom));
      else if (r < 95) push_gaps($urandom_range(1, 24));
      else             fifo_q.push_back(10'h300);
    end
    wait_drain("rand", 20000);

    // Asynchronous reset in the middle of a frame
    gap_pct    = 0;
    ready_mode = 0;
    push_byte(8'hA5); push_byte(8'h12); push_byte(8'h34);
    wait_drain("rst_a", 100);
    check("rst_mid_busy", busy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    settle(2);
    check("rst_after_busy", busy, 0);
    check("rst_after_valid", bus_if.cmd_valid, 0);
    push_frame(8'h44, 8'h55, 8'h66, 0);
    wait_drain("rst_b", 100);
    check("rst_frame_op", last_op, 8'h44);
    check("rst_frame_data", last_data, 8'h66);

    check("total_fires", dut_fires, m_fires);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
